// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, transmitter state encoding and a baud helper.
package mmio_uart_pkg;

    // Register offsets selected by addr[2:1]
    localparam logic [1:0] RegTxData = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegBaud   = 2'd2;
    localparam logic [1:0] RegRsvd   = 2'd3;

    // STATUS register bit positions
    localparam int unsigned StFullBit  = 0;
    localparam int unsigned StEmptyBit = 1;
    localparam int unsigned StBusyBit  = 2;
    localparam int unsigned StOvfBit   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // A BAUD value of zero still yields one clock per bit
    function automatic logic [15:0] eff_period(input logic [15:0] baud);
        return (baud == 16'd0) ? 16'd1 : baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-around pointers carrying one extra bit to tell
// full from empty. Read data is the current head (no fall-through of writes).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A push while full is accepted only when a pop frees the slot this cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage array, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus. Holds the bus
// decode, register file, TX FIFO instance and the serialising FSM.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RST   = 16'd16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    input  logic                  rd_en,
    input  logic [1:0]            wr_en,
    input  logic [15:0]           din,
    output logic [15:0]           dout,
    output logic                  o_txd,
    output logic                  o_irq
);

    logic [1:0]  reg_sel;
    logic        rd_req, rd_status, push_req, baud_wr, ovf_set;
    logic        fifo_full, fifo_empty, fsm_pop, bit_end;
    logic [7:0]  fifo_rdata;
    logic [15:0] status, rdata;

    logic [15:0] dout_q, baud_q;
    logic        ovf_q, irq_q, txd_q;
    tx_state_t   state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] baud_cnt_q, period_q;

    logic unused_addr;
    assign unused_addr = ^{addr[ADDR_WIDTH-1:3], addr[0]};

    assign reg_sel   = addr[2:1];
    assign rd_req    = en & rd_en;
    assign rd_status = rd_req & (reg_sel == RegStatus);
    assign push_req  = en & wr_en[0] & (reg_sel == RegTxData);
    assign baud_wr   = en & (|wr_en) & (reg_sel == RegBaud);
    // Dropped byte: full and nothing leaves the FIFO this cycle
    assign ovf_set   = push_req & fifo_full & ~fsm_pop;

    assign bit_end = (baud_cnt_q == period_q - 16'd1);
    assign fsm_pop = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (fsm_pop),
        .wdata_i (din[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Read mux over current register contents
    always_comb begin
        status             = '0;
        status[StFullBit]  = fifo_full;
        status[StEmptyBit] = fifo_empty;
        status[StBusyBit]  = (state_q != IDLE);
        status[StOvfBit]   = ovf_q;
        rdata              = '0;
        case (reg_sel)
            RegStatus: rdata = status;
            RegBaud:   rdata = baud_q;
            default:   rdata = '0;
        endcase
    end

    // Bus-side registers: read data, BAUD, sticky overflow, interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            baud_q <= BAUD_RST;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b1;
        end else begin
            if (rd_req) dout_q <= rdata;
            if (baud_wr && wr_en[0]) baud_q[7:0]  <= din[7:0];
            if (baud_wr && wr_en[1]) baud_q[15:8] <= din[15:8];
            ovf_q <= ovf_set | (ovf_q & ~rd_status);
            irq_q <= fifo_empty & (state_q == IDLE);
        end
    end

    // TX FSM; the bit period is sampled at every bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            period_q   <= eff_period(BAUD_RST);
            txd_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fsm_pop) begin
                        state_q    <= START;
                        shift_q    <= fifo_rdata;
                        baud_cnt_q <= '0;
                        period_q   <= eff_period(baud_q);
                        txd_q      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q    <= DATA;
                        txd_q      <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= '0;
                        period_q   <= eff_period(baud_q);
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        period_q   <= eff_period(baud_q);
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (fsm_pop) begin
                            // Back-to-back frame: start bit follows stop bit directly
                            state_q  <= START;
                            shift_q  <= fifo_rdata;
                            period_q <= eff_period(baud_q);
                            txd_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout  = dout_q;
    assign o_txd = txd_q;
    assign o_irq = irq_q;

endmodule
